// File: rtl/gc_dispatch_if.sv
// Fork, index request/grant and end-report signals between a parent core, N_CORE
// worker cores and the gc_dispatch global-counter dispatcher.
interface gc_dispatch_if #(
    parameter int unsigned N_CORE   = 4,
    parameter int unsigned GC_WIDTH = 32,
    parameter int unsigned GD_WIDTH = 32
);
    logic                       fork_valid;
    logic                       fork_ready;
    logic [GC_WIDTH-1:0]        fork_gc;
    logic [GD_WIDTH-1:0]        fork_gd;
    logic [GC_WIDTH-1:0]        fork_limit;
    logic [N_CORE-1:0]          req_valid;
    logic [N_CORE-1:0]          req_ready;
    logic [N_CORE-1:0]          gnt_valid;
    logic [N_CORE*GC_WIDTH-1:0] gnt_gc;
    logic [N_CORE-1:0]          gnt_exh;
    logic [N_CORE-1:0]          core_end;
    logic                       busy;
    logic                       join_done;

    modport master (
        output fork_valid, fork_gc, fork_gd, fork_limit, req_valid, core_end,
        input  fork_ready, req_ready, gnt_valid, gnt_gc, gnt_exh, busy, join_done
    );

    modport slave (
        input  fork_valid, fork_gc, fork_gd, fork_limit, req_valid, core_end,
        output fork_ready, req_ready, gnt_valid, gnt_gc, gnt_exh, busy, join_done
    );
endinterface

// File: rtl/gc_dispatch.sv
// Global-counter loop dispatcher: hands unique iteration indices to N_CORE cores and
// signals loop join. Define GC_LIMIT_EN to compile in bound checking and gnt_exh.
module gc_dispatch #(
    parameter int unsigned N_CORE   = 4,
    parameter int unsigned GC_WIDTH = 32,
    parameter int unsigned GD_WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    gc_dispatch_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                     state_q;
    logic [GC_WIDTH-1:0]        gc_q;
    logic [GC_WIDTH-1:0]        gd_q;
    logic [N_CORE-1:0]          end_seen_q;
    logic [N_CORE-1:0]          gnt_valid_q;
    logic [N_CORE-1:0]          gnt_exh_q;
    logic [N_CORE*GC_WIDTH-1:0] gnt_gc_q;
    logic                       join_done_q;

    logic                       run;
    logic [N_CORE-1:0]          accept;
    logic                       all_ended;
    logic [GC_WIDTH-1:0]        fork_gd_ext;
    logic [N_CORE*GC_WIDTH-1:0] grant_idx;
    logic [N_CORE*GC_WIDTH-1:0] grant_gc;
    logic [N_CORE-1:0]          grant_exh;
    logic [GC_WIDTH-1:0]        gc_next;
    logic [GC_WIDTH-1:0]        gc_d;

    assign run         = (state_q == StRun);
    assign accept      = run ? bus.req_valid : '0;
    assign all_ended   = &(end_seen_q | bus.core_end);
    assign fork_gd_ext = GC_WIDTH'($signed(bus.fork_gd));

    // Prefix-sum chain: each accepted lower-index core pushes the base by one stride.
    always_comb begin
        logic [GC_WIDTH-1:0] acc;
        acc       = gc_q;
        grant_idx = '0;
        grant_gc  = '0;
        for (int i = 0; i < N_CORE; i++) begin
            grant_idx[i*GC_WIDTH +: GC_WIDTH] = acc;
            if (accept[i]) begin
                grant_gc[i*GC_WIDTH +: GC_WIDTH] = acc;
                acc = acc + gd_q;
            end
        end
        gc_next = acc;
    end

`ifdef GC_LIMIT_EN
    logic [GC_WIDTH-1:0] limit_q;
    logic                exh_q;
    logic                gd_neg;
    logic                gd_pos;
    logic [N_CORE-1:0]   oor;

    assign gd_neg = gd_q[GC_WIDTH-1];
    assign gd_pos = !gd_neg && (gd_q != '0);

    always_comb begin
        oor = '0;
        for (int i = 0; i < N_CORE; i++) begin
            oor[i] = (gd_pos && ($signed(grant_idx[i*GC_WIDTH +: GC_WIDTH]) >= $signed(limit_q)))
                  || (gd_neg && ($signed(grant_idx[i*GC_WIDTH +: GC_WIDTH]) <= $signed(limit_q)));
        end
    end

    assign grant_exh = {N_CORE{exh_q}} | oor;
    // Once exhausted the counter freezes; the exhausting cycle itself still advances it.
    assign gc_d      = exh_q ? gc_q : gc_next;
`else
    logic unused_limit;

    assign unused_limit = ^bus.fork_limit;
    assign grant_exh    = '0;
    assign gc_d         = gc_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gc_q        <= '0;
            gd_q        <= '0;
            end_seen_q  <= '0;
            gnt_valid_q <= '0;
            gnt_gc_q    <= '0;
            gnt_exh_q   <= '0;
            join_done_q <= 1'b0;
`ifdef GC_LIMIT_EN
            limit_q     <= '0;
            exh_q       <= 1'b0;
`endif
        end else begin
            gnt_valid_q <= accept;
            gnt_gc_q    <= grant_gc;
            gnt_exh_q   <= accept & grant_exh;
            join_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.fork_valid) begin
                        state_q    <= StRun;
                        gc_q       <= bus.fork_gc;
                        gd_q       <= fork_gd_ext;
                        end_seen_q <= '0;
`ifdef GC_LIMIT_EN
                        limit_q    <= bus.fork_limit;
                        exh_q      <= 1'b0;
`endif
                    end
                end
                StRun: begin
                    gc_q <= gc_d;
`ifdef GC_LIMIT_EN
                    exh_q <= exh_q | (|(accept & oor));
`endif
                    if (all_ended) begin
                        state_q     <= StIdle;
                        end_seen_q  <= '0;
                        join_done_q <= 1'b1;
                    end else begin
                        end_seen_q <= end_seen_q | bus.core_end;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.fork_ready = !run;
    assign bus.req_ready  = {N_CORE{run}};
    assign bus.gnt_valid  = gnt_valid_q;
    assign bus.gnt_gc     = gnt_gc_q;
    assign bus.gnt_exh    = gnt_exh_q;
    assign bus.busy       = run;
    assign bus.join_done  = join_done_q;
endmodule

// File: tb/tb_gc_dispatch.sv
// Randomised self-checking bench for gc_dispatch against a popcount/multiply index model.
// Expectations follow GC_LIMIT_EN when the macro is defined for the build.
module tb_gc_dispatch;
    localparam int unsigned N   = 4;
    localparam int unsigned GCW = 32;
    localparam int unsigned GDW = 32;
`ifdef GC_LIMIT_EN
    localparam bit LimitEn = 1'b1;
`else
    localparam bit LimitEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    gc_dispatch_if #(.N_CORE(N), .GC_WIDTH(GCW), .GD_WIDTH(GDW)) bus ();

    gc_dispatch #(.N_CORE(N), .GC_WIDTH(GCW), .GD_WIDTH(GDW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    // Reference model state
    logic [GCW-1:0]   m_gc;
    logic [GCW-1:0]   m_gd;
    logic [GCW-1:0]   m_limit;
    bit               m_exh;
    logic [N-1:0]     exp_vld;
    logic [N-1:0]     exp_exh;
    logic [N*GCW-1:0] exp_gc;
    logic [N*GCW-1:0] gc_mask;

    function automatic bit out_of_range(input logic [GCW-1:0] v);
        if ($signed(m_gd) > 0) return $signed(v) >= $signed(m_limit);
        if ($signed(m_gd) < 0) return $signed(v) <= $signed(m_limit);
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fork_loop(input logic [GCW-1:0] gc, input logic [GDW-1:0] gd,
                             input logic [GCW-1:0] limit);
        bus.fork_valid = 1'b1;
        bus.fork_gc    = gc;
        bus.fork_gd    = gd;
        bus.fork_limit = limit;
        m_gc    = gc;
        m_gd    = GCW'($signed(gd));
        m_limit = LimitEn ? limit : '0;
        m_exh   = 1'b0;
        tick();
        bus.fork_valid = 1'b0;
    endtask

    // Index of core i is base + (number of lower requesters) * stride.
    task automatic drive_req(input logic [N-1:0] r);
        int             k;
        bit             hit;
        logic [GCW-1:0] v;
        k = 0;
        hit = 1'b0;
        exp_vld = r;
        exp_exh = '0;
        exp_gc  = '0;
        gc_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                v = m_gc + GCW'(k) * m_gd;
                exp_gc[i*GCW +: GCW]  = v;
                gc_mask[i*GCW +: GCW] = '1;
                if (LimitEn && (m_exh || out_of_range(v))) begin
                    exp_exh[i] = 1'b1;
                    hit = 1'b1;
                end
                k++;
            end
        end
        if (!m_exh) m_gc = m_gc + GCW'(k) * m_gd;
        m_exh = m_exh | hit;
        bus.req_valid = r;
        tick();
        bus.req_valid = '0;
    endtask

    task automatic finish_loop();
        bus.core_end = '1;
        tick();
        bus.core_end = '0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.fork_valid = 1'b0;
        bus.fork_gc    = '0;
        bus.fork_gd    = '0;
        bus.fork_limit = '0;
        bus.req_valid  = '0;
        bus.core_end   = '0;
        #12;
        checks++;
        if (bus.fork_ready !== 1'b1) begin
            errors++; $display("FAIL reset_fork_ready: got %b want 1", bus.fork_ready);
        end
        checks++;
        if (bus.req_ready !== '0) begin
            errors++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
        end
        checks++;
        if (bus.gnt_valid !== '0 || bus.gnt_exh !== '0) begin
            errors++;
            $display("FAIL reset_gnt: got vld=%b exh=%b want 0/0", bus.gnt_valid, bus.gnt_exh);
        end
        checks++;
        if (bus.gnt_gc !== '0) begin
            errors++; $display("FAIL reset_gnt_gc: got %h want 0", bus.gnt_gc);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.join_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_join: got %b/%b want 0/0", bus.busy, bus.join_done);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.fork_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: busy=%b ready=%b want 0/1", bus.busy, bus.fork_ready);
        end
    endtask

    task automatic test_sparse();
        fork_loop(32'd100, 32'd4, 32'd1000);
        checks++;
        if (bus.busy !== 1'b1 || bus.fork_ready !== 1'b0 || bus.req_ready !== '1) begin
            errors++;
            $display("FAIL sparse_fork: busy=%b ready=%b req_ready=%b want 1/0/1111",
                     bus.busy, bus.fork_ready, bus.req_ready);
        end
        drive_req(4'b1010);
        checks++;
        if (bus.gnt_valid !== 4'b1010 || bus.gnt_gc[GCW +: GCW] !== 32'd100
            || bus.gnt_gc[3*GCW +: GCW] !== 32'd104 || bus.gnt_exh !== '0) begin
            errors++;
            $display("FAIL sparse_grant: vld=%b c1=%0d c3=%0d exh=%b want 1010/100/104/0000",
                     bus.gnt_valid, bus.gnt_gc[GCW +: GCW], bus.gnt_gc[3*GCW +: GCW],
                     bus.gnt_exh);
        end
        drive_req(4'b0001);
        checks++;
        if (bus.gnt_valid !== 4'b0001 || bus.gnt_gc[0 +: GCW] !== 32'd108) begin
            errors++;
            $display("FAIL sparse_advance: vld=%b c0=%0d want 0001/108",
                     bus.gnt_valid, bus.gnt_gc[0 +: GCW]);
        end
        tick();
        checks++;
        if (bus.gnt_valid !== '0) begin
            errors++; $display("FAIL sparse_pulse: vld=%b want 0000", bus.gnt_valid);
        end
        finish_loop();
    endtask

`ifdef GC_LIMIT_EN
    task automatic test_exhaust();
        fork_loop(32'd0, 32'd1, 32'd10);
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd3, 32'd2, 32'd1, 32'd0} || bus.gnt_exh !== 4'b0000) begin
            errors++; $display("FAIL exh_c1: gc=%h exh=%b want 3..0/0000", bus.gnt_gc, bus.gnt_exh);
        end
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd7, 32'd6, 32'd5, 32'd4} || bus.gnt_exh !== 4'b0000) begin
            errors++; $display("FAIL exh_c2: gc=%h exh=%b want 7..4/0000", bus.gnt_gc, bus.gnt_exh);
        end
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd11, 32'd10, 32'd9, 32'd8} || bus.gnt_exh !== 4'b1100) begin
            errors++; $display("FAIL exh_c3: gc=%h exh=%b want 11..8/1100", bus.gnt_gc, bus.gnt_exh);
        end
        drive_req('1);
        checks++;
        if (bus.gnt_exh !== 4'b1111 || bus.gnt_valid !== 4'b1111) begin
            errors++; $display("FAIL exh_sticky: vld=%b exh=%b want 1111/1111",
                               bus.gnt_valid, bus.gnt_exh);
        end
        drive_req(4'b0001);
        checks++;
        if (bus.gnt_gc[0 +: GCW] !== 32'd12 || bus.gnt_exh !== 4'b0001) begin
            errors++; $display("FAIL exh_hold: c0=%0d exh=%b want 12/0001",
                               bus.gnt_gc[0 +: GCW], bus.gnt_exh);
        end
        finish_loop();
    endtask
`else
    task automatic test_wrap();
        fork_loop(32'hFFFF_FFFE, 32'd1, 32'd0);
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE} || bus.gnt_exh !== '0) begin
            errors++; $display("FAIL wrap_c1: gc=%h exh=%b want 1,0,ffffffff,fffffffe/0000",
                               bus.gnt_gc, bus.gnt_exh);
        end
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd5, 32'd4, 32'd3, 32'd2} || bus.gnt_exh !== '0) begin
            errors++; $display("FAIL wrap_c2: gc=%h exh=%b want 5..2/0000", bus.gnt_gc, bus.gnt_exh);
        end
        finish_loop();
    endtask
`endif

    task automatic test_neg_stride();
        fork_loop(32'd10, 32'hFFFF_FFFD, 32'd0);
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd1, 32'd4, 32'd7, 32'd10} || bus.gnt_exh !== '0) begin
            errors++; $display("FAIL neg_c1: gc=%h exh=%b want 1,4,7,10/0000",
                               bus.gnt_gc, bus.gnt_exh);
        end
        drive_req('1);
        checks++;
        if (bus.gnt_valid !== exp_vld || (bus.gnt_gc & gc_mask) !== exp_gc
            || bus.gnt_exh !== exp_exh) begin
            errors++; $display("FAIL neg_c2: vld=%b gc=%h exh=%b want %b/%h/%b",
                               bus.gnt_valid, bus.gnt_gc, bus.gnt_exh, exp_vld, exp_gc, exp_exh);
        end
        finish_loop();
    endtask

    task automatic test_back_to_back();
        logic [GCW-1:0] gc;
        logic [GDW-1:0] gd;
        logic [GCW-1:0] limit;
        int             s;
        for (int l = 0; l < 3; l++) begin
            gc = $urandom;
            s  = (l == 2) ? 0 : int'($urandom_range(16)) - 8;
            gd = GDW'(s);
            limit = gc + GCW'(int'($urandom_range(200)) - 100);
            fork_loop(gc, gd, limit);
            for (int c = 0; c < 50; c++) begin
                drive_req(N'($urandom));
                checks++;
                if (bus.gnt_valid !== exp_vld || (bus.gnt_gc & gc_mask) !== exp_gc
                    || bus.gnt_exh !== exp_exh || bus.req_ready !== '1) begin
                    errors++;
                    $display("FAIL b2b[%0d.%0d]: vld=%b gc=%h exh=%b want %b/%h/%b",
                             l, c, bus.gnt_valid, bus.gnt_gc, bus.gnt_exh, exp_vld, exp_gc,
                             exp_exh);
                end
            end
            finish_loop();
        end
    endtask

    task automatic test_join_refork();
        fork_loop(32'd5, 32'd2, 32'd100);
        bus.core_end = 4'b0101;
        drive_req(4'b0100);
        checks++;
        if (bus.gnt_valid !== 4'b0100 || bus.gnt_gc[2*GCW +: GCW] !== 32'd5
            || bus.join_done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL join_partial: vld=%b c2=%0d join=%b busy=%b want 0100/5/0/1",
                               bus.gnt_valid, bus.gnt_gc[2*GCW +: GCW], bus.join_done, bus.busy);
        end
        bus.core_end = 4'b1010;
        drive_req(4'b0000);
        bus.core_end = '0;
        checks++;
        if (bus.join_done !== 1'b1 || bus.fork_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL join_done: join=%b ready=%b busy=%b want 1/1/0",
                               bus.join_done, bus.fork_ready, bus.busy);
        end
        fork_loop(32'd200, 32'd1, 32'd1000);
        checks++;
        if (bus.busy !== 1'b1 || bus.join_done !== 1'b0 || bus.fork_ready !== 1'b0) begin
            errors++; $display("FAIL refork: busy=%b join=%b ready=%b want 1/0/0",
                               bus.busy, bus.join_done, bus.fork_ready);
        end
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd203, 32'd202, 32'd201, 32'd200} || bus.gnt_exh !== '0) begin
            errors++; $display("FAIL refork_grant: gc=%h exh=%b want 203..200/0000",
                               bus.gnt_gc, bus.gnt_exh);
        end
        finish_loop();
    endtask

    task automatic test_midrun_reset();
        fork_loop(32'd50, 32'd1, 32'd51);
        bus.core_end = 4'b0111;
        drive_req('1);
        bus.core_end = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt_valid !== '0 || bus.gnt_gc !== '0 || bus.gnt_exh !== '0 || bus.busy !== 1'b0
            || bus.fork_ready !== 1'b1 || bus.req_ready !== '0 || bus.join_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: vld=%b gc=%h exh=%b busy=%b ready=%b req_ready=%b",
                     bus.gnt_valid, bus.gnt_gc, bus.gnt_exh, bus.busy, bus.fork_ready,
                     bus.req_ready);
        end
        #2;
        rst_n = 1'b1;
        tick();
        fork_loop(32'd7, 32'd1, 32'd1000);
        bus.core_end = 4'b1000;
        tick();
        bus.core_end = '0;
        checks++;
        if (bus.join_done !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL reset_end_seen: join=%b busy=%b want 0/1",
                               bus.join_done, bus.busy);
        end
        drive_req('1);
        checks++;
        if (bus.gnt_gc !== {32'd10, 32'd9, 32'd8, 32'd7} || bus.gnt_exh !== '0) begin
            errors++; $display("FAIL reset_clean: gc=%h exh=%b want 10..7/0000",
                               bus.gnt_gc, bus.gnt_exh);
        end
        finish_loop();
    endtask

    initial begin
        test_reset();
        test_sparse();
`ifdef GC_LIMIT_EN
        test_exhaust();
`else
        test_wrap();
`endif
        test_neg_stride();
        test_back_to_back();
        test_join_refork();
        test_midrun_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
